// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width rules and Gray/binary conversion shared by both FIFO pointer controllers.
package fifo_pkg;
    localparam int PTR_MAX = 16;

    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    // Zero-extended operands convert correctly, so callers cast to and from PTR_MAX bits.
    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_ptr_cnt.sv
// gray_ptr_cnt: binary pointer counter with enable, registered Gray copy and next-value exports.
module gray_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    output logic [W-2:0] ADDR,
    output logic [W-1:0] GRAY,
    output logic [W-1:0] BNEXT,
    output logic [W-1:0] GNEXT
);
    logic [W-1:0] bin_q, bin_d, gray_q, gray_d;

    always_comb begin
        bin_d  = bin_q + W'(EN);
        gray_d = W'(bin2gray(PTR_MAX'(bin_d)));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign ADDR  = bin_q[W-2:0];
    assign GRAY  = gray_q;
    assign BNEXT = bin_d;
    assign GNEXT = gray_d;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer controller of the async FIFO; produces FULL, ALMOST_FULL,
// fill level and a sticky overflow flag from the synchronized Gray read pointer.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADD_WIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 W_INC,
    input  logic [ADD_WIDTH:0]   RPTR_SYNC,
    input  logic                 OVF_CLR,
    output logic                 W_CLKEN,
    output logic [ADD_WIDTH-1:0] W_ADDR,
    output logic [ADD_WIDTH:0]   WPTR_GRAY,
    output logic                 FULL,
    output logic                 ALMOST_FULL,
    output logic [ADD_WIDTH:0]   W_LEVEL,
    output logic                 OVF
);
    localparam int P = ptr_w(ADD_WIDTH);

    logic         acc;
    logic [P-1:0] bnext, gnext, rbin;
    logic [P-1:0] level_q, level_d;
    logic         full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;

    assign acc = W_INC & ~full_q;

    gray_ptr_cnt #(.W(P)) u_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (acc),
        .ADDR (W_ADDR),
        .GRAY (WPTR_GRAY),
        .BNEXT(bnext),
        .GNEXT(gnext)
    );

    // Full when the next write pointer laps the read pointer: top two Gray bits inverted.
    always_comb begin
        rbin    = P'(gray2bin(PTR_MAX'(RPTR_SYNC)));
        full_d  = gnext == {~RPTR_SYNC[P-1:P-2], RPTR_SYNC[P-3:0]};
        level_d = bnext - rbin;
        afull_d = level_d >= P'(AFULL_THRESH);
        ovf_d   = (W_INC & full_q) | (ovf_q & ~OVF_CLR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            afull_q <= afull_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign W_CLKEN     = acc;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign W_LEVEL     = level_q;
    assign OVF         = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed vectors with hand-computed expectations for fifo_wr_ctrl (ADD_WIDTH=3, AFULL_THRESH=6).
module tb_fifo_wr_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       W_INC = 1'b1;
    logic [3:0] RPTR_SYNC = 4'd0;
    logic       OVF_CLR = 1'b0;
    logic       W_CLKEN;
    logic [2:0] W_ADDR;
    logic [3:0] WPTR_GRAY;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] W_LEVEL;
    logic       OVF;

    int n_chk = 0;
    int n_pass = 0;

    fifo_wr_ctrl #(.ADD_WIDTH(3), .AFULL_THRESH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .W_INC      (W_INC),
        .RPTR_SYNC  (RPTR_SYNC),
        .OVF_CLR    (OVF_CLR),
        .W_CLKEN    (W_CLKEN),
        .W_ADDR     (W_ADDR),
        .WPTR_GRAY  (WPTR_GRAY),
        .FULL       (FULL),
        .ALMOST_FULL(ALMOST_FULL),
        .W_LEVEL    (W_LEVEL),
        .OVF        (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] exp_b, prev_g, exp_g;

    initial begin
        step();
        step();
        check("rst_gray", 32'(WPTR_GRAY), 32'd0);
        check("rst_addr", 32'(W_ADDR), 32'd0);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_afull", 32'(ALMOST_FULL), 32'd0);
        check("rst_level", 32'(W_LEVEL), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_clken", 32'(W_CLKEN), 32'd1);
        RST = 1'b1;
        check("first_addr", 32'(W_ADDR), 32'd0);
        check("first_clken", 32'(W_CLKEN), 32'd1);

        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("fill_level%0d", k), 32'(W_LEVEL), 32'(k));
            check($sformatf("fill_afull%0d", k), 32'(ALMOST_FULL), 32'(k >= 6));
            check($sformatf("fill_full%0d", k), 32'(FULL), 32'(k == 8));
            check($sformatf("fill_addr%0d", k), 32'(W_ADDR), 32'(k % 8));
        end
        check("full_gray", 32'(WPTR_GRAY), 32'b1100);

        check("ovf_clken", 32'(W_CLKEN), 32'd0);
        step();
        check("ovf_gray", 32'(WPTR_GRAY), 32'b1100);
        check("ovf_set", 32'(OVF), 32'd1);
        check("ovf_full", 32'(FULL), 32'd1);
        OVF_CLR = 1'b1;
        step();
        check("ovf_set_wins", 32'(OVF), 32'd1);
        W_INC = 1'b0;
        step();
        check("ovf_clr", 32'(OVF), 32'd0);
        OVF_CLR = 1'b0;

        RPTR_SYNC = 4'b0010;
        step();
        check("drain_full", 32'(FULL), 32'd0);
        check("drain_level", 32'(W_LEVEL), 32'd5);
        check("drain_afull", 32'(ALMOST_FULL), 32'd0);

        W_INC = 1'b1;
        step();
        check("pre_level6", 32'(W_LEVEL), 32'd6);
        step();
        check("pre_level7", 32'(W_LEVEL), 32'd7);
        check("pre_full", 32'(FULL), 32'd0);
        RPTR_SYNC = 4'b0110;
        check("sim_clken", 32'(W_CLKEN), 32'd1);
        step();
        check("sim_level", 32'(W_LEVEL), 32'd7);
        check("sim_full", 32'(FULL), 32'd0);
        check("sim_gray", 32'(WPTR_GRAY), 32'b1110);

        exp_b = 4'd11;
        for (int k = 0; k < 20; k++) begin
            prev_g = WPTR_GRAY;
            RPTR_SYNC = WPTR_GRAY;
            step();
            exp_b = exp_b + 4'd1;
            exp_g = exp_b ^ (exp_b >> 1);
            check($sformatf("wrap_gray%0d", k), 32'(WPTR_GRAY), 32'(exp_g));
            check($sformatf("wrap_1bit%0d", k), 32'($countones(prev_g ^ WPTR_GRAY)), 32'd1);
            check($sformatf("wrap_addr%0d", k), 32'(W_ADDR), 32'(exp_b[2:0]));
            check($sformatf("wrap_full%0d", k), 32'(FULL), 32'd0);
            check($sformatf("wrap_level%0d", k), 32'(W_LEVEL), 32'd1);
        end
        check("wrap_ovf", 32'(OVF), 32'd0);

        RST = 1'b0;
        #1;
        check("mid_rst_gray", 32'(WPTR_GRAY), 32'd0);
        check("mid_rst_addr", 32'(W_ADDR), 32'd0);
        check("mid_rst_level", 32'(W_LEVEL), 32'd0);
        RPTR_SYNC = 4'd0;
        RST = 1'b1;
        check("post_rst_addr", 32'(W_ADDR), 32'd0);
        check("post_rst_clken", 32'(W_CLKEN), 32'd1);
        step();
        check("post_rst_addr1", 32'(W_ADDR), 32'd1);
        check("post_rst_level", 32'(W_LEVEL), 32'd1);
        check("post_rst_gray", 32'(WPTR_GRAY), 32'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer controller for the UART system's asynchronous FIFO. It owns the binary write pointer and the memory write address, publishes the Gray-coded write pointer for the read domain's two-flop pointer synchronizer, and consumes the already-synchronized Gray read pointer. From these it generates FULL, ALMOST_FULL, a fill level and a sticky overflow flag. It runs entirely in the write clock domain and sits between the write-domain producer, the FIFO memory and the pointer synchronizers.

## Interface
- ADD_WIDTH, 3: memory address width; depth = 2^ADD_WIDTH; must be >= 2; pointer width P = ADD_WIDTH+1.
- AFULL_THRESH, 6: fill level at or above which ALMOST_FULL asserts; range 1..2^ADD_WIDTH.

- CLK  in  1  write-domain clock.
- RST  in  1  asynchronous, active-low reset.
- W_INC  in  1  write request, one word per cycle.
- RPTR_SYNC  in  P  Gray read pointer, already synchronized into the CLK domain.
- OVF_CLR  in  1  clears OVF.
- W_CLKEN  out  1  memory write enable, combinational: W_INC & ~FULL.
- W_ADDR  out  ADD_WIDTH  memory write address, equal to wbin[ADD_WIDTH-1:0].
- WPTR_GRAY  out  P  registered Gray write pointer, driven to the read-domain synchronizer.
- FULL  out  1  registered full flag.
- ALMOST_FULL  out  1  registered almost-full flag.
- W_LEVEL  out  P  registered fill level, 0..2^ADD_WIDTH.
- OVF  out  1  sticky overflow flag.

## Operation
- State: wbin (P bits, binary), wgray (P bits), FULL, ALMOST_FULL, W_LEVEL, OVF. No other FSM.
- Accept: acc = W_INC & ~FULL. bnext = wbin + acc, modulo 2^P. gnext = bnext ^ (bnext >> 1).
- Every edge: wbin <= bnext, wgray <= gnext. WPTR_GRAY = wgray; it changes by exactly one bit per accepted write.
- Full: FULL <= (gnext == {~RPTR_SYNC[P-1:P-2], RPTR_SYNC[P-3:0]}).
- Level: rbin = gray-to-binary(RPTR_SYNC). W_LEVEL <= (bnext - rbin) mod 2^P. ALMOST_FULL <= (that value >= AFULL_THRESH).
- Overflow: W_INC & FULL sets OVF. OVF_CLR clears it. If set and clear occur in the same cycle, set wins. A rejected write changes no pointer.
- Full and level are pessimistic because RPTR_SYNC lags. The block never reports less fill than actually exists, and never writes past a true full.
- Reset: asynchronous, active-low. All registers go to 0: WPTR_GRAY=0, W_ADDR=0, FULL=0, ALMOST_FULL=0, W_LEVEL=0, OVF=0. W_CLKEN follows W_INC while FULL=0.

## Timing
- W_CLKEN is combinational from W_INC and FULL, in the same cycle. The memory captures data at W_ADDR on that same edge.
- WPTR_GRAY, W_ADDR, FULL, ALMOST_FULL and W_LEVEL all update on the edge that consumes the accepted write (latency 1).
- FULL asserts on the edge of the write that fills the last slot. There is no back-to-back overshoot.
- A change on RPTR_SYNC is reflected in FULL, ALMOST_FULL and W_LEVEL at the next edge.
- A write and a read-pointer change in the same cycle are both folded into the same update.
- Pointers wrap from 2^P-1 to 0 with no special handling. The Gray MSB-pair inversion distinguishes full from empty.
- Reset asserted mid-burst clears state immediately. After release, the first accepted write lands at address 0.

## Structure
- Shared package fifo_pkg holds:
  - the bin2gray and gray2bin functions (width-generic, P bits);
  - the localparam rules for pointer width (ADD_WIDTH+1) and depth (1<<ADD_WIDTH).
- The read-side controller reuses the same package.
- One sub-module is natural: gray_ptr_cnt. It contains the binary counter with enable, the registered Gray output and bnext/gnext exports. The read-side controller instantiates it too.
- The write-side controller adds the full comparison, level, ALMOST_FULL and OVF logic around it.

## Test plan
All scenarios use ADD_WIDTH=3 and AFULL_THRESH=6.
- Reset: hold RST=0 with W_INC=1 -> all outputs 0 and W_CLKEN=1. Release RST -> first write goes to W_ADDR=0.
- Fill: RPTR_SYNC=0, 8 consecutive W_INC -> ALMOST_FULL=1 after the 6th edge. After the 8th edge: FULL=1, W_LEVEL=8, WPTR_GRAY=4'b1100, W_ADDR=0.
- Overflow: FULL=1, then W_INC=1 -> W_CLKEN=0, WPTR_GRAY unchanged, OVF=1 next edge. OVF_CLR=1 together with W_INC=1 -> OVF stays 1. OVF_CLR alone -> OVF=0.
- Drain: while full, set RPTR_SYNC=4'b0010 (bin 3) -> next edge FULL=0, W_LEVEL=5, ALMOST_FULL=0.
- Simultaneous events: W_LEVEL=7 with RPTR_SYNC advancing by 1 and W_INC=1 in the same cycle -> W_LEVEL stays 7 and FULL stays 0.
- Wrap: 20 writes with RPTR_SYNC tracking WPTR_GRAY one cycle late -> pointer wraps 15->0, each WPTR_GRAY step differs by exactly one bit, FULL never asserts, OVF stays 0.
